// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e         - bit-level FSM state encodings (3 bits)
//   PARITY_*             - values for the PARITY_MODE parameter
//   CLKS_PER_BIT_DEFAULT - 100 MHz clock / 115200 baud
//   calc_parity()        - parity bit for a byte under a given mode
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int CLKS_PER_BIT_DEFAULT = 868;

  // Even parity makes the total count of ones even.
  // Odd parity is the inverse of even parity.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-side handshake and serial output of the UART transmitter.
//   i_TX_DV     - single-cycle strobe; the byte is accepted only while idle
//   i_TX_Byte   - byte to send; it is sampled on the accepting edge
//   o_TX_Active - high while a frame is in flight
//   o_TX_Serial - registered serial line; it idles high
//   o_TX_Done   - one-cycle pulse after the stop bit
// master: the upstream controller. slave: the transmitter.
interface uart_tx_if;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Active;
  logic       o_TX_Serial;
  logic       o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Active, o_TX_Serial, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Active, o_TX_Serial, o_TX_Done
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Frame format: start bit (0), 8 data bits LSB first, an optional parity bit,
// and one stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles.
//   i_Clock - system clock; all logic runs on the rising edge
//   i_Rst   - synchronous reset, active-high; it aborts any frame in flight
//   tx      - uart_tx_if.slave (byte strobe in; serial, active and done out)
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit, 2..65535
//   PARITY_MODE  - 0 none, 1 even, 2 odd; 3 behaves as none
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int PARITY_MODE  = PARITY_NONE
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  uart_tx_if.slave   tx
);

  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam bit          PARITY_EN = (PARITY_MODE == PARITY_EVEN) ||
                                      (PARITY_MODE == PARITY_ODD);

  uart_state_e state, state_nxt;
  logic [15:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  tx_byte, tx_byte_nxt;
  logic        serial, serial_nxt;
  logic        active, active_nxt;
  logic        done, done_nxt;
  logic        bit_end;

  // The last cycle of the current serial bit.
  assign bit_end = (clk_cnt == LAST_CNT);

  always_ff @(posedge i_Clock) begin
    // NOTE: state registers use non-blocking assignments so that every
    // register samples the values from before the edge. Blocking assignments
    // would make the order of statements change the hardware.
    if (i_Rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      // NOTE: the byte latch is reset so that a frame aborted by reset does
      // not leave stale data visible in the latch.
      tx_byte <= '0;
      serial  <= 1'b1;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      tx_byte <= tx_byte_nxt;
      serial  <= serial_nxt;
      active  <= active_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case. Then
    // no path leaves a signal unassigned, and the tool infers no latch.
    state_nxt   = state;
    clk_cnt_nxt = bit_end ? 16'd0 : clk_cnt + 16'd1;
    bit_idx_nxt = bit_idx;
    tx_byte_nxt = tx_byte;
    serial_nxt  = serial;
    active_nxt  = active;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        serial_nxt  = 1'b1;
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        active_nxt  = 1'b0;
        if (tx.i_TX_DV) begin
          tx_byte_nxt = tx.i_TX_Byte;
          active_nxt  = 1'b1;
          serial_nxt  = 1'b0;
          state_nxt   = START;
        end
      end

      START: begin
        if (bit_end) begin
          serial_nxt = tx_byte[0];
          state_nxt  = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx != 3'd7) begin
            bit_idx_nxt = bit_idx + 3'd1;
            serial_nxt  = tx_byte[bit_idx + 3'd1];
          end else begin
            bit_idx_nxt = '0;
            if (PARITY_EN) begin
              serial_nxt = calc_parity(tx_byte, PARITY_MODE);
              state_nxt  = PARITY;
            end else begin
              serial_nxt = 1'b1;
              state_nxt  = STOP;
            end
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          serial_nxt = 1'b1;
          state_nxt  = STOP;
        end
      end

      STOP: begin
        if (bit_end) begin
          active_nxt = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = DONE;
        end
      end

      DONE: begin
        clk_cnt_nxt = '0;
        serial_nxt  = 1'b1;
        state_nxt   = IDLE;
      end

      default: begin
        // An unused encoding recovers to idle with the line high.
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        serial_nxt  = 1'b1;
        active_nxt  = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign tx.o_TX_Serial = serial;
  assign tx.o_TX_Active = active;
  assign tx.o_TX_Done   = done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// It has six transmitter instances with different CLKS_PER_BIT and
// PARITY_MODE settings. All instances share the clock and the reset.
// The bench drives inputs and samples outputs on the falling edge.
module tb_uart_tx;

  localparam int NU = 6;

  logic i_Clock = 1'b0;
  logic i_Rst;
  always #5 i_Clock = ~i_Clock;

  logic [NU-1:0] dv;
  logic [7:0]    din [NU];
  logic [NU-1:0] ser, act, dn;

  int tests = 0;
  int fails = 0;

  logic cap  [0:511];
  logic acap [0:511];
  logic dcap [0:511];

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();
  uart_tx_if if4 ();
  uart_tx_if if5 ();

  assign if0.i_TX_DV = dv[0];  assign if0.i_TX_Byte = din[0];
  assign if1.i_TX_DV = dv[1];  assign if1.i_TX_Byte = din[1];
  assign if2.i_TX_DV = dv[2];  assign if2.i_TX_Byte = din[2];
  assign if3.i_TX_DV = dv[3];  assign if3.i_TX_Byte = din[3];
  assign if4.i_TX_DV = dv[4];  assign if4.i_TX_Byte = din[4];
  assign if5.i_TX_DV = dv[5];  assign if5.i_TX_Byte = din[5];

  assign ser[0] = if0.o_TX_Serial; assign act[0] = if0.o_TX_Active; assign dn[0] = if0.o_TX_Done;
  assign ser[1] = if1.o_TX_Serial; assign act[1] = if1.o_TX_Active; assign dn[1] = if1.o_TX_Done;
  assign ser[2] = if2.o_TX_Serial; assign act[2] = if2.o_TX_Active; assign dn[2] = if2.o_TX_Done;
  assign ser[3] = if3.o_TX_Serial; assign act[3] = if3.o_TX_Active; assign dn[3] = if3.o_TX_Done;
  assign ser[4] = if4.o_TX_Serial; assign act[4] = if4.o_TX_Active; assign dn[4] = if4.o_TX_Done;
  assign ser[5] = if5.o_TX_Serial; assign act[5] = if5.o_TX_Active; assign dn[5] = if5.o_TX_Done;

  // u0: 4 clk/bit 8N1; u1: even; u2: odd; u3: 8 clk/bit; u4: 2 clk/bit; u5: mode 3
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_MODE(0)) u0 (.i_Clock(i_Clock), .i_Rst(i_Rst), .tx(if0));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_MODE(1)) u1 (.i_Clock(i_Clock), .i_Rst(i_Rst), .tx(if1));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_MODE(2)) u2 (.i_Clock(i_Clock), .i_Rst(i_Rst), .tx(if2));
  uart_tx #(.CLKS_PER_BIT(8), .PARITY_MODE(0)) u3 (.i_Clock(i_Clock), .i_Rst(i_Rst), .tx(if3));
  uart_tx #(.CLKS_PER_BIT(2), .PARITY_MODE(0)) u4 (.i_Clock(i_Clock), .i_Rst(i_Rst), .tx(if4));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_MODE(3)) u5 (.i_Clock(i_Clock), .i_Rst(i_Rst), .tx(if5));

  // Frame bit k of 'frame' is the k-th transmitted bit (bit 0 = start).
  typedef struct {
    string      name;
    int         unit;
    logic [7:0] data;
    int         cpb;
    int         nbits;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // The captured line must equal exp for cycles first..first+len-1.
  task automatic check_span(input string name, input int first, input int len, input logic exp);
    logic got;
    got = exp;
    for (int i = 0; i < len; i++)
      if (cap[first + i] !== exp) got = cap[first + i];
    check(name, 32'(got), 32'(exp));
  endtask

  // Record n cycles of unit u. Call it on the falling edge of cycle 1.
  task automatic capture(input int u, input int n);
    for (int c = 1; c <= n; c++) begin
      cap[c]  = ser[u];
      acap[c] = act[u];
      dcap[c] = dn[u];
      @(negedge i_Clock);
    end
  endtask

  task automatic run_frame(input string name, input int u, input logic [7:0] data,
                           input int cpb, input int nbits, input logic [10:0] frame);
    int n;
    int act_cnt;
    int early_done;
    n = nbits * cpb;
    @(negedge i_Clock);
    dv[u]  = 1'b1;
    din[u] = data;
    @(negedge i_Clock);
    dv[u]  = 1'b0;
    din[u] = ~data;             // the byte must come from the latch
    capture(u, n + 2);
    for (int k = 0; k < nbits; k++)
      check_span($sformatf("%s_bit%0d", name, k), k * cpb + 1, cpb, frame[k]);
    act_cnt = 0;
    early_done = 0;
    for (int c = 1; c <= n; c++) begin
      if (acap[c] === 1'b1) act_cnt++;
      if (dcap[c] !== 1'b0) early_done++;
    end
    check({name, "_active_len"}, 32'(act_cnt), 32'(n));
    check({name, "_done_early"}, 32'(early_done), 32'd0);
    check({name, "_done_pulse"}, 32'(dcap[n + 1]), 32'd1);
    check({name, "_active_off"}, 32'(acap[n + 1]), 32'd0);
    check({name, "_done_clear"}, 32'(dcap[n + 2]), 32'd0);
    check({name, "_line_idle"}, 32'(cap[n + 2]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [9:0] f1, f2;
    int bad_s [NU];
    int bad_a [NU];
    int bad_d [NU];
    int hi_bad, dn_cnt, act_cnt;

    vecs[0] = '{"a5_8n1",   0, 8'hA5, 4, 10, 11'b0_1_10100101_0};
    vecs[1] = '{"a5_even",  1, 8'hA5, 4, 11, 11'b1_0_10100101_0};
    vecs[2] = '{"a5_odd",   2, 8'hA5, 4, 11, 11'b1_1_10100101_0};
    vecs[3] = '{"01_even",  1, 8'h01, 4, 11, 11'b1_1_00000001_0};
    vecs[4] = '{"01_odd",   2, 8'h01, 4, 11, 11'b1_0_00000001_0};
    vecs[5] = '{"80_cpb2",  4, 8'h80, 2, 10, 11'b0_1_10000000_0};
    vecs[6] = '{"a5_mode3", 5, 8'hA5, 4, 10, 11'b0_1_10100101_0};

    // Reset for 3 cycles, then 50 idle cycles on every unit.
    i_Rst = 1'b1;
    dv = '0;
    for (int u = 0; u < NU; u++) din[u] = 8'h00;
    repeat (3) @(posedge i_Clock);
    @(negedge i_Clock);
    i_Rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      bad_s[u] = 0; bad_a[u] = 0; bad_d[u] = 0;
    end
    repeat (50) begin
      for (int u = 0; u < NU; u++) begin
        if (ser[u] !== 1'b1) bad_s[u]++;
        if (act[u] !== 1'b0) bad_a[u]++;
        if (dn[u]  !== 1'b0) bad_d[u]++;
      end
      @(negedge i_Clock);
    end
    for (int u = 0; u < NU; u++) begin
      check($sformatf("reset_serial_u%0d", u), 32'(bad_s[u]), 32'd0);
      check($sformatf("reset_active_u%0d", u), 32'(bad_a[u]), 32'd0);
      check($sformatf("reset_done_u%0d", u),   32'(bad_d[u]), 32'd0);
    end

    // Table of single frames.
    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].name, vecs[i].unit, vecs[i].data, vecs[i].cpb,
                vecs[i].nbits, vecs[i].frame);

    // Back-to-back on u3 (8 clk/bit) with the strobe held high.
    // 0xFF is presented for one cycle in the middle of the first frame.
    f1 = 10'b1_00111100_0;      // 0x3C
    f2 = 10'b1_11000011_0;      // 0xC3
    @(negedge i_Clock);
    dv[3]  = 1'b1;
    din[3] = 8'h3C;
    @(negedge i_Clock);
    for (int c = 1; c <= 170; c++) begin
      cap[c]  = ser[3];
      dcap[c] = dn[3];
      if (c == 20)  din[3] = 8'hFF;
      if (c == 21)  din[3] = 8'hC3;
      if (c == 100) dv[3]  = 1'b0;
      @(negedge i_Clock);
    end
    for (int k = 0; k < 10; k++)
      check_span($sformatf("b2b_f1_bit%0d", k), k * 8 + 1, 8, f1[k]);
    check_span("b2b_gap_high", 81, 2, 1'b1);
    check("b2b_done_before", 32'(dcap[80]), 32'd0);
    check("b2b_done_f1", 32'(dcap[81]), 32'd1);
    check("b2b_done_after", 32'(dcap[82]), 32'd0);
    for (int k = 0; k < 10; k++)
      check_span($sformatf("b2b_f2_bit%0d", k), 83 + k * 8, 8, f2[k]);
    check("b2b_done_f2", 32'(dcap[163]), 32'd1);
    check_span("b2b_no_third", 164, 7, 1'b1);

    // Reset during data bit 3 of 0x00 on u0 (cycles 17..20).
    @(negedge i_Clock);
    dv[0]  = 1'b1;
    din[0] = 8'h00;
    @(negedge i_Clock);
    dv[0] = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      cap[c] = ser[0];
      if (c == 18) i_Rst = 1'b1;
      @(negedge i_Clock);
    end
    i_Rst = 1'b0;
    check_span("abort_start", 1, 4, 1'b0);
    check_span("abort_data_low", 5, 14, 1'b0);
    hi_bad = 0; dn_cnt = 0; act_cnt = 0;
    repeat (60) begin
      if (ser[0] !== 1'b1) hi_bad++;
      if (dn[0]  !== 1'b0) dn_cnt++;
      if (act[0] !== 1'b0) act_cnt++;
      @(negedge i_Clock);
    end
    check("abort_line_high", 32'(hi_bad), 32'd0);
    check("abort_no_done", 32'(dn_cnt), 32'd0);
    check("abort_inactive", 32'(act_cnt), 32'd0);
    run_frame("55_after_abort", 0, 8'h55, 4, 10, 11'b0_1_01010101_0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
